// File: rtl/bus_mem_responder.sv
// Responder end of the valid/ready memory bus: word-addressed RAM with byte-strobed
// writes, a programmable number of wait states and out-of-range flagging.
module bus_mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_addr,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    output logic [31:0] s_rdata,
    output logic        s_err
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [3:0]    count;
    logic [3:0]    count_next;
    logic          enter_resp;

    logic [31:0]   off;
    logic          in_range;
    logic [AW-1:0] idx;
    logic          is_write;

    logic [31:0]   mem [DEPTH_WORDS];

    // Offset wraps, so addresses below BASE_ADDR land far above SPAN and decode as out of range.
    assign off      = s_addr - BASE_ADDR;
    assign in_range = (off < SPAN);
    assign idx      = off[AW+1:2];
    assign is_write = (s_wstrb != 4'b0000);

    always_comb begin
        state_next = state;
        count_next = count;
        enter_resp = 1'b0;
        case (state)
            ST_IDLE: begin
                if (s_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                        count_next = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            ST_WAIT: begin
                // A master dropping valid before ready abandons the access entirely.
                if (!s_valid) begin
                    state_next = ST_IDLE;
                    count_next = 4'd0;
                end else if (count == 4'd0) begin
                    state_next = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    count_next = count - 4'd1;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                count_next = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            count   <= 4'd0;
            s_ready <= 1'b0;
            s_err   <= 1'b0;
            s_rdata <= 32'h0000_0000;
        end else begin
            state   <= state_next;
            count   <= count_next;
            s_ready <= enter_resp;
            s_err   <= enter_resp && !in_range;
            if (enter_resp) begin
                s_rdata <= (!is_write && in_range) ? mem[idx] : 32'h0000_0000;
            end
        end
    end

    // RAM is deliberately not reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (enter_resp && is_write && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (s_wstrb[i]) begin
                    mem[idx][8*i +: 8] <= s_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder: three instances cover zero, three and five
// wait states plus a nonzero base address; table vectors then multi-cycle sequences.
module tb_bus_mem_responder;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;

    logic        valid0, valid1, valid2;
    logic        ready0, ready1, ready2;
    logic        err0, err1, err2;
    logic [31:0] rdata0, rdata1, rdata2;

    int          sel;
    logic        ready_m;
    logic        err_m;
    logic [31:0] rdata_m;

    int checks;
    int errors;

    bus_mem_responder #(.BASE_ADDR(32'h0000_0000), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .s_valid(valid0), .s_ready(ready0), .s_addr(addr),
        .s_wdata(wdata), .s_wstrb(wstrb), .s_rdata(rdata0), .s_err(err0)
    );

    bus_mem_responder #(.BASE_ADDR(32'h0000_0000), .DEPTH_WORDS(1024), .WAIT_CYCLES(3)) dut1 (
        .clk(clk), .reset(reset), .s_valid(valid1), .s_ready(ready1), .s_addr(addr),
        .s_wdata(wdata), .s_wstrb(wstrb), .s_rdata(rdata1), .s_err(err1)
    );

    bus_mem_responder #(.BASE_ADDR(32'h8000_0000), .DEPTH_WORDS(1024), .WAIT_CYCLES(5)) dut2 (
        .clk(clk), .reset(reset), .s_valid(valid2), .s_ready(ready2), .s_addr(addr),
        .s_wdata(wdata), .s_wstrb(wstrb), .s_rdata(rdata2), .s_err(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        ready_m = ready0;
        err_m   = err0;
        rdata_m = rdata0;
        case (sel)
            1: begin ready_m = ready1; err_m = err1; rdata_m = rdata1; end
            2: begin ready_m = ready2; err_m = err2; rdata_m = rdata2; end
            default: ;
        endcase
    end

    typedef struct {
        int          sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          lat;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_valid(input int s, input logic v);
        case (s)
            0: valid0 = v;
            1: valid1 = v;
            default: valid2 = v;
        endcase
    endtask

    task automatic do_access(input int s, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] st, input int lat, input logic [31:0] exp_rdata,
                             input logic exp_err, input string name);
        int n;
        bit got;
        @(negedge clk);
        sel   = s;
        addr  = a;
        wdata = d;
        wstrb = st;
        set_valid(s, 1'b1);
        n   = 0;
        got = 0;
        while (!got && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (ready_m) got = 1;
        end
        check({name, " latency"}, n, lat);
        check({name, " rdata"}, rdata_m, exp_rdata);
        check({name, " err"}, {31'd0, err_m}, {31'd0, exp_err});
        @(negedge clk);
        set_valid(s, 1'b0);
        @(posedge clk);
        #1;
        check({name, " pulse"}, {31'd0, ready_m}, 32'd0);
    endtask

    initial begin
        int n;
        int seen;
        checks = 0;
        errors = 0;
        sel    = 0;
        reset  = 1'b1;
        valid0 = 1'b0;
        valid1 = 1'b0;
        valid2 = 1'b0;
        addr   = 32'h0;
        wdata  = 32'h0;
        wstrb  = 4'h0;

        vecs[0]  = '{0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1, 32'h0000_0000, 1'b0};
        vecs[1]  = '{0, 32'h0000_0010, 32'h0000_0000, 4'h0, 1, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{0, 32'h0000_0020, 32'h1122_3344, 4'hF, 1, 32'h0000_0000, 1'b0};
        vecs[3]  = '{0, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 1, 32'h0000_0000, 1'b0};
        vecs[4]  = '{0, 32'h0000_0020, 32'h0000_0000, 4'h0, 1, 32'h11BB_33DD, 1'b0};
        vecs[5]  = '{0, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 1, 32'h0000_0000, 1'b0};
        vecs[6]  = '{0, 32'h0000_1000, 32'h0000_0055, 4'hF, 1, 32'h0000_0000, 1'b1};
        vecs[7]  = '{0, 32'h0000_0000, 32'h0000_0000, 4'h0, 1, 32'hCAFE_F00D, 1'b0};
        vecs[8]  = '{0, 32'h0000_1000, 32'h0000_0000, 4'h0, 1, 32'h0000_0000, 1'b1};
        vecs[9]  = '{0, 32'h0000_0013, 32'h0000_0000, 4'h0, 1, 32'hDEAD_BEEF, 1'b0};
        vecs[10] = '{0, 32'h0000_0FFC, 32'h0102_0304, 4'hF, 1, 32'h0000_0000, 1'b0};
        vecs[11] = '{0, 32'h0000_0FFC, 32'h0000_0000, 4'h0, 1, 32'h0102_0304, 1'b0};
        vecs[12] = '{1, 32'h0000_0010, 32'h1234_5678, 4'hF, 4, 32'h0000_0000, 1'b0};
        vecs[13] = '{1, 32'h0000_0010, 32'h0000_0000, 4'h0, 4, 32'h1234_5678, 1'b0};
        vecs[14] = '{2, 32'h8000_0000, 32'h0BAD_CAFE, 4'hF, 6, 32'h0000_0000, 1'b0};
        vecs[15] = '{2, 32'h8000_0004, 32'h1357_9BDF, 4'hF, 6, 32'h0000_0000, 1'b0};
        vecs[16] = '{2, 32'h7FFF_FFFC, 32'h0000_0000, 4'h0, 6, 32'h0000_0000, 1'b1};
        vecs[17] = '{2, 32'h8000_1000, 32'h0000_0000, 4'h0, 6, 32'h0000_0000, 1'b1};
        vecs[18] = '{2, 32'h8000_0000, 32'h0000_0000, 4'h0, 6, 32'h0BAD_CAFE, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check("reset ready", {29'd0, ready0, ready1, ready2}, 32'd0);
        check("reset err", {29'd0, err0, err1, err2}, 32'd0);
        check("reset rdata0", rdata0, 32'd0);
        check("reset rdata1", rdata1, 32'd0);
        check("reset rdata2", rdata2, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            do_access(vecs[i].sel, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].lat,
                      vecs[i].rdata, vecs[i].err, $sformatf("vec%0d", i));
        end

        // Valid held across the response: exactly one IDLE gap, then a fresh 4-cycle access.
        @(negedge clk);
        sel   = 1;
        addr  = 32'h0000_0010;
        wstrb = 4'h0;
        valid1 = 1'b1;
        n = 0;
        seen = 0;
        while (seen == 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (ready1) seen = 1;
        end
        check("hold first latency", n, 4);
        @(posedge clk);
        #1;
        check("hold gap ready", {31'd0, ready1}, 32'd0);
        n = 1;
        seen = 0;
        while (seen == 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (ready1) seen = 1;
        end
        check("hold second latency", n, 5);
        check("hold second rdata", rdata1, 32'h1234_5678);
        @(negedge clk);
        valid1 = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (ready1) seen++;
        end
        check("hold no third ready", seen, 0);

        // Abort: valid dropped during wait states, no response and no write.
        @(negedge clk);
        sel   = 2;
        addr  = 32'h8000_0000;
        wdata = 32'hFFFF_FFFF;
        wstrb = 4'hF;
        valid2 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        valid2 = 1'b0;
        seen = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (ready2) seen++;
        end
        check("abort no ready", seen, 0);
        do_access(2, 32'h8000_0000, 32'h0, 4'h0, 6, 32'h0BAD_CAFE, 1'b0, "abort readback");

        // Reset in the middle of a write's wait states.
        @(negedge clk);
        sel   = 2;
        addr  = 32'h8000_0004;
        wdata = 32'hFFFF_FFFF;
        wstrb = 4'hF;
        valid2 = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("pre-reset ready", {31'd0, ready2}, 32'd0);
        #2;
        reset  = 1'b1;
        valid2 = 1'b0;
        #1;
        check("async reset ready", {31'd0, ready2}, 32'd0);
        check("async reset err", {31'd0, err2}, 32'd0);
        check("async reset rdata2", rdata2, 32'd0);
        check("async reset rdata0", rdata0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        do_access(2, 32'h8000_0004, 32'h0, 4'h0, 6, 32'h1357_9BDF, 1'b0, "reset readback");
        do_access(0, 32'h0000_0FFC, 32'h0, 4'h0, 1, 32'h0102_0304, 1'b0, "ram retained");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
